pdpw8ke_fifo_ctrl: RTL and testbench

Single-clock FIFO controller that sequences one PDPW8KE pseudo-dual-port EBR as a 512 x 18 write / 1024 x 9 read width-converting FIFO. Generates write/read addresses, clock enables and output-register enable. Maintains fill level and status flags, and produces a read-valid strobe aligned to the EBR output latency. Write data (DI[17:0]) and read data (DO[8:0]) connect directly between user logic and the EBR; this block carries only control.

---
 rtl/pdpw8ke_fifo_ctrl.sv | 114 +++++++++++
 tb/tb_pdpw8ke_fifo_ctrl.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/pdpw8ke_fifo_ctrl.sv
// Control sequencer for a PDPW8KE EBR used as a 512x18 write / 1024x9 read FIFO.
// Produces EBR addresses and enables, fill level, status flags and a latency-aligned read-valid strobe.
module pdpw8ke_fifo_ctrl #(
    parameter string REGMODE   = "NOREG",
    parameter int    AF_THRESH = 1020,
    parameter int    AE_THRESH = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        wr_en,
    input  logic        rd_en,
    output logic [8:0]  adw,
    output logic [1:0]  be,
    output logic        cew,
    output logic [9:0]  adr,
    output logic        cer,
    output logic        ocer,
    output logic        rd_valid,
    output logic        full,
    output logic        empty,
    output logic        almost_full,
    output logic        almost_empty,
    output logic [10:0] fill,
    output logic        overflow,
    output logic        underflow
);

    localparam bit          OUTREG_MODE = (REGMODE == "OUTREG");
    localparam logic [10:0] AF_TH       = 11'(AF_THRESH);
    localparam logic [10:0] AE_TH       = 11'(AE_THRESH);

    logic [9:0]  wptr_r;
    logic [10:0] rptr_r;
    logic [10:0] fill_r;
    logic        full_r;
    logic        empty_r;
    logic        af_r;
    logic        ae_r;
    logic        ovf_r;
    logic        unf_r;
    logic [1:0]  vpipe_r;

    logic        wacc_s;
    logic        racc_s;
    logic        wrej_s;
    logic        rrej_s;
    logic [10:0] fill_next_s;
    logic        ptr_wrap_unused_s;

    // Accept/reject decisions and next occupancy; a write adds two 9-bit units.
    always_comb begin
        wacc_s      = 1'b0;
        racc_s      = 1'b0;
        wrej_s      = 1'b0;
        rrej_s      = 1'b0;
        fill_next_s = fill_r;
        if (rst) begin
            wacc_s = 1'b0;
            racc_s = 1'b0;
        end else begin
            wacc_s = wr_en & ~full_r;
            racc_s = rd_en & ~empty_r;
            wrej_s = wr_en & full_r;
            rrej_s = rd_en & empty_r;
        end
        fill_next_s = fill_r + {9'd0, wacc_s, 1'b0} - {10'd0, racc_s};
    end

    // Pointers, fill level, registered flags and the read-valid shift register.
    always_ff @(posedge clk) begin
        if (rst) begin
            wptr_r  <= 10'd0;
            rptr_r  <= 11'd0;
            fill_r  <= 11'd0;
            full_r  <= 1'b0;
            empty_r <= 1'b1;
            af_r    <= 1'b0;
            ae_r    <= 1'b1;
            ovf_r   <= 1'b0;
            unf_r   <= 1'b0;
            vpipe_r <= 2'b00;
        end else begin
            wptr_r  <= wptr_r + {9'd0, wacc_s};
            rptr_r  <= rptr_r + {10'd0, racc_s};
            fill_r  <= fill_next_s;
            full_r  <= (fill_next_s > 11'd1022);
            empty_r <= (fill_next_s == 11'd0);
            af_r    <= (fill_next_s >= AF_TH);
            ae_r    <= (fill_next_s <= AE_TH);
            ovf_r   <= wrej_s;
            unf_r   <= rrej_s;
            vpipe_r <= {vpipe_r[0], racc_s};
        end
    end

    // Wrap bits are kept for debug visibility only; flags come from the fill count.
    assign ptr_wrap_unused_s = wptr_r[9] ^ rptr_r[10];

    assign adw          = wptr_r[8:0];
    assign adr          = rptr_r[9:0];
    assign be           = 2'b11;
    assign ocer         = 1'b1;
    assign cew          = wacc_s;
    assign cer          = racc_s;
    assign rd_valid     = OUTREG_MODE ? vpipe_r[1] : vpipe_r[0];
    assign full         = full_r;
    assign empty        = empty_r;
    assign almost_full  = af_r;
    assign almost_empty = ae_r;
    assign fill         = fill_r;
    assign overflow     = ovf_r;
    assign underflow    = unf_r;

endmodule

// File: tb/tb_pdpw8ke_fifo_ctrl.sv
// Scoreboard bench: NOREG and OUTREG instances share stimulus; each drives its own EBR model,
// and a queue-based FIFO model supplies expected flags, addresses and read data.
module tb_pdpw8ke_fifo_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        wr_en = 1'b0;
    logic        rd_en = 1'b0;
    logic [17:0] wr_data = 18'd0;

    logic [8:0]  adw_a, adw_b;
    logic [1:0]  be_a, be_b;
    logic        cew_a, cew_b, cer_a, cer_b, ocer_a, ocer_b;
    logic [9:0]  adr_a, adr_b;
    logic        rdv_a, rdv_b, full_a, full_b, empty_a, empty_b;
    logic        af_a, af_b, ae_a, ae_b, ovf_a, ovf_b, unf_a, unf_b;
    logic [10:0] fill_a, fill_b;

    int checks = 0;
    int failures = 0;

    logic [8:0] mq[$];
    logic [8:0] expa[$];
    logic [8:0] expb[$];
    int wcnt = 0;
    int rcnt = 0;

    logic [17:0] mem_a [512];
    logic [17:0] mem_b [512];
    logic [8:0]  do0_a, do0_b, do1_b;

    always #5 clk = ~clk;

    pdpw8ke_fifo_ctrl #(.REGMODE("NOREG"), .AF_THRESH(1020), .AE_THRESH(2)) dut_a (
        .clk(clk), .rst(rst), .wr_en(wr_en), .rd_en(rd_en),
        .adw(adw_a), .be(be_a), .cew(cew_a), .adr(adr_a), .cer(cer_a), .ocer(ocer_a),
        .rd_valid(rdv_a), .full(full_a), .empty(empty_a), .almost_full(af_a),
        .almost_empty(ae_a), .fill(fill_a), .overflow(ovf_a), .underflow(unf_a)
    );

    pdpw8ke_fifo_ctrl #(.REGMODE("OUTREG"), .AF_THRESH(1020), .AE_THRESH(2)) dut_b (
        .clk(clk), .rst(rst), .wr_en(wr_en), .rd_en(rd_en),
        .adw(adw_b), .be(be_b), .cew(cew_b), .adr(adr_b), .cer(cer_b), .ocer(ocer_b),
        .rd_valid(rdv_b), .full(full_b), .empty(empty_b), .almost_full(af_b),
        .almost_empty(ae_b), .fill(fill_b), .overflow(ovf_b), .underflow(unf_b)
    );

    // Behavioural EBRs: read-before-write, low unit at even read address.
    always @(posedge clk) begin
        if (cew_a) mem_a[adw_a] <= wr_data;
        if (cer_a) do0_a <= adr_a[0] ? mem_a[adr_a[9:1]][17:9] : mem_a[adr_a[9:1]][8:0];
        if (cew_b) mem_b[adw_b] <= wr_data;
        if (cer_b) do0_b <= adr_b[0] ? mem_b[adr_b[9:1]][17:9] : mem_b[adr_b[9:1]][8:0];
        do1_b <= do0_b;
    end

    task automatic chk(input string nm, input logic [17:0] act, input logic [17:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h t=%0t", nm, act, exp, $time);
        end
    endtask

    // Monitors: pop an expected unit whenever an instance presents read data.
    always @(negedge clk) begin
        if (rdv_a === 1'b1) begin
            if (expa.size() == 0) begin
                checks++; failures++;
                $display("FAIL rdv_a_unexpected actual=1 required=0 t=%0t", $time);
            end else chk("data_a", {9'd0, do0_a}, {9'd0, expa.pop_front()});
        end
        if (rdv_b === 1'b1) begin
            if (expb.size() == 0) begin
                checks++; failures++;
                $display("FAIL rdv_b_unexpected actual=1 required=0 t=%0t", $time);
            end else chk("data_b", {9'd0, do1_b}, {9'd0, expb.pop_front()});
        end
    end

    task automatic step(input logic we, input logic re, input logic rs, input logic [17:0] d);
        logic ew, er, eo, eu;
        int   n;
        logic [8:0] u;
        wr_en = we; rd_en = re; rst = rs; wr_data = d;
        #1;
        n  = mq.size();
        ew = !rs && we && (n <= 1022);
        er = !rs && re && (n != 0);
        eo = !rs && we && (n > 1022);
        eu = !rs && re && (n == 0);
        chk("cew_a", {17'd0, cew_a}, {17'd0, ew});
        chk("cew_b", {17'd0, cew_b}, {17'd0, ew});
        chk("cer_a", {17'd0, cer_a}, {17'd0, er});
        chk("cer_b", {17'd0, cer_b}, {17'd0, er});
        chk("adw_a", {9'd0, adw_a}, 18'(wcnt % 512));
        chk("adr_b", {8'd0, adr_b}, 18'(rcnt % 1024));
        if (rs) begin
            mq.delete(); wcnt = 0; rcnt = 0;
        end else begin
            if (er) begin
                u = mq.pop_front();
                expa.push_back(u); expb.push_back(u);
                rcnt++;
            end
            if (ew) begin
                mq.push_back(d[8:0]); mq.push_back(d[17:9]);
                wcnt++;
            end
        end
        @(posedge clk);
        #1;
        if (rs) begin
            expa.delete(); expb.delete();
        end
        n = mq.size();
        chk("fill_a", {7'd0, fill_a}, 18'(n));
        chk("fill_b", {7'd0, fill_b}, 18'(n));
        chk("full_a", {17'd0, full_a}, {17'd0, n > 1022});
        chk("empty_b", {17'd0, empty_b}, {17'd0, n == 0});
        chk("empty_a", {17'd0, empty_a}, {17'd0, n == 0});
        chk("af_a", {17'd0, af_a}, {17'd0, n >= 1020});
        chk("ae_b", {17'd0, ae_b}, {17'd0, n <= 2});
        chk("ovf_a", {17'd0, ovf_a}, {17'd0, eo});
        chk("unf_b", {17'd0, unf_b}, {17'd0, eu});
        chk("be_a", {16'd0, be_a}, 18'd3);
        chk("ocer_b", {17'd0, ocer_b}, 18'd1);
    endtask

    task automatic do_reset();
        step(1'b0, 1'b0, 1'b1, 18'd0);
        step(1'b0, 1'b0, 1'b1, 18'd0);
        step(1'b0, 1'b0, 1'b0, 18'd0);
    endtask

    initial begin
        do_reset();
        chk("rst_rdv_a", {17'd0, rdv_a}, 18'd0);
        chk("rst_adr_a", {8'd0, adr_a}, 18'd0);

        // Single word, two unit reads.
        step(1'b1, 1'b0, 1'b0, 18'h3FE01);
        step(1'b0, 1'b1, 1'b0, 18'd0);
        step(1'b0, 1'b1, 1'b0, 18'd0);
        repeat (3) step(1'b0, 1'b0, 1'b0, 18'd0);

        // Underflow on empty.
        step(1'b0, 1'b1, 1'b0, 18'd0);
        step(1'b0, 1'b0, 1'b0, 18'd0);

        // Fill to full and one rejected write.
        do_reset();
        repeat (513) step(1'b1, 1'b0, 1'b0, 18'($urandom));
        step(1'b0, 1'b0, 1'b0, 18'd0);
        chk("full_adw_a", {9'd0, adw_a}, 18'd0);

        // Continuous simultaneous traffic from fill 4.
        do_reset();
        repeat (2) step(1'b1, 1'b0, 1'b0, 18'($urandom));
        repeat (2000) step(1'b1, 1'b1, 1'b0, 18'($urandom));

        // Random traffic.
        repeat (3000) step(($urandom_range(0, 99) < 45), ($urandom_range(0, 99) < 55), 1'b0, 18'($urandom));
        while (mq.size() != 0) step(1'b0, 1'b1, 1'b0, 18'd0);
        repeat (3) step(1'b0, 1'b0, 1'b0, 18'd0);
        chk("drain_a", 18'(expa.size()), 18'd0);
        chk("drain_b", 18'(expb.size()), 18'd0);

        // Reset the cycle after a read is accepted.
        step(1'b1, 1'b0, 1'b0, 18'($urandom));
        step(1'b1, 1'b0, 1'b0, 18'($urandom));
        step(1'b0, 1'b1, 1'b0, 18'd0);
        step(1'b0, 1'b0, 1'b1, 18'd0);
        step(1'b0, 1'b0, 1'b0, 18'd0);
        chk("midrst_rdv_b", {17'd0, rdv_b}, 18'd0);
        step(1'b1, 1'b0, 1'b0, 18'h1A2B3);
        step(1'b0, 1'b1, 1'b0, 18'd0);
        step(1'b0, 1'b1, 1'b0, 18'd0);
        repeat (3) step(1'b0, 1'b0, 1'b0, 18'd0);
        chk("final_a", 18'(expa.size()), 18'd0);
        chk("final_b", 18'(expb.size()), 18'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
